// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the APB register block.
// Optional character timeout is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   utrrst,
  input  logic                   fifoen,
  input  logic                   rx_fifo_clear,
  input  logic [1:0]             rx_trigger,
  input  logic                   error_check,
  input  logic [7:0]             rsr_data,
  input  logic                   frame_error,
  input  logic                   parity_error,
  input  logic                   sample_edge,
  input  logic                   rbr_read,
  input  logic                   lsr_read,
  output logic [7:0]             rbr_data,
  output logic                   data_ready,
  output logic                   lsr_frame_error,
  output logic                   lsr_parity_error,
  output logic                   overrun_error,
  output logic                   rx_fifo_error,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   trigger_reached,
  output logic                   rx_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (LW > 5) ? LW : 5;
  localparam logic [LW-1:0] ONE = LW'(1'b1);

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_addr_s;
  logic [LW-1:0] level_r, level_nxt_s, err_cnt_r, err_nxt_s, cap_s;
  logic          fifoen_r, overrun_r;
  logic          flush_s, empty_s, full_s, push_req_s, do_push_s, do_pop_s, overwrite_s;
  logic          set_ovr_s;
  logic [9:0]    entry_s, head_s;
  logic [CW-1:0] trig_lvl_s;

  function automatic logic has_error(input logic [9:0] e);
    return e[9] | e[8];
  endfunction

  // Flush detection, push/pop qualification and next-state arithmetic.
  always_comb begin
    cap_s       = fifoen_r ? LW'(DEPTH) : ONE;
    flush_s     = rx_fifo_clear | utrrst | (fifoen ^ fifoen_r);
    empty_s     = (level_r == {LW{1'b0}});
    full_s      = (level_r == cap_s);
    push_req_s  = error_check & ~flush_s;
    do_pop_s    = rbr_read & ~empty_s & ~flush_s;
    do_push_s   = push_req_s & (~full_s | do_pop_s);
    // holding-register mode replaces the unread character instead of dropping it
    overwrite_s = push_req_s & full_s & ~do_pop_s & ~fifoen_r;
    set_ovr_s   = push_req_s & full_s & ~do_pop_s;
    entry_s     = {frame_error, parity_error, rsr_data};
    wr_addr_s   = overwrite_s ? rd_ptr_r : wr_ptr_r;
    head_s      = empty_s ? 10'h000 : mem_r[rd_ptr_r];

    level_nxt_s = level_r;
    case ({do_push_s, do_pop_s})
      2'b10:   level_nxt_s = level_r + ONE;
      2'b01:   level_nxt_s = level_r - ONE;
      default: level_nxt_s = level_r;
    endcase

    err_nxt_s = err_cnt_r;
    if ((do_push_s | overwrite_s) & has_error(entry_s)) begin
      err_nxt_s = err_nxt_s + ONE;
    end else begin
      err_nxt_s = err_nxt_s;
    end
    if ((do_pop_s | overwrite_s) & has_error(head_s)) begin
      err_nxt_s = err_nxt_s - ONE;
    end else begin
      err_nxt_s = err_nxt_s;
    end

    trig_lvl_s = CW'(5'd1);
    case (rx_trigger)
      2'b00:   trig_lvl_s = CW'(5'd1);
      2'b01:   trig_lvl_s = CW'(5'd4);
      2'b10:   trig_lvl_s = CW'(5'd8);
      2'b11:   trig_lvl_s = CW'(5'd14);
      default: trig_lvl_s = CW'(5'd1);
    endcase
  end

  // Pointers, occupancy, error count and registered mode.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= {LW{1'b0}};
      err_cnt_r <= {LW{1'b0}};
      fifoen_r  <= 1'b0;
    end else if (flush_s) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= {LW{1'b0}};
      err_cnt_r <= {LW{1'b0}};
      fifoen_r  <= fifoen;
    end else begin
      wr_ptr_r  <= do_push_s ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
      rd_ptr_r  <= do_pop_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
      level_r   <= level_nxt_s;
      err_cnt_r <= err_nxt_s;
      fifoen_r  <= fifoen;
    end
  end

  // Sticky overrun; a new overrun wins over a same-cycle LSR read.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      overrun_r <= 1'b0;
    end else if (set_ovr_s) begin
      overrun_r <= 1'b1;
    end else if (utrrst | lsr_read) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Entry storage; contents are qualified by the level so no reset is needed.
  always_ff @(posedge pclk) begin
    if (do_push_s | overwrite_s) begin
      mem_r[wr_addr_s] <= entry_s;
    end
  end

  assign rbr_data         = head_s[7:0];
  assign lsr_parity_error = head_s[8];
  assign lsr_frame_error  = head_s[9];
  assign data_ready       = ~empty_s;
  assign overrun_error    = overrun_r;
  assign rx_fifo_error    = (err_cnt_r != {LW{1'b0}});
  assign rx_level         = level_r;
  assign trigger_reached  = fifoen_r ? (CW'(level_r) >= trig_lvl_s) : ~empty_s;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_r;

  // Character timeout: counts idle sample ticks while data waits, saturating at the limit.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt_r <= {TW{1'b0}};
      tmo_r     <= 1'b0;
    end else if (flush_s | do_push_s | overwrite_s | do_pop_s | empty_s) begin
      tmo_cnt_r <= {TW{1'b0}};
      tmo_r     <= 1'b0;
    end else if (sample_edge & fifoen_r & (tmo_cnt_r != TW'(TIMEOUT_TICKS))) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
      tmo_r     <= (tmo_cnt_r == TW'(TIMEOUT_TICKS - 1));
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
      tmo_r     <= tmo_r;
    end
  end

  assign rx_timeout = tmo_r;
`else
  logic unused_s;
  assign unused_s   = sample_edge ^ TIMEOUT_TICKS[0];
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus a pop scoreboard.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int TICKS = 640;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          pclk = 1'b0;
  logic          preset, utrrst, fifoen, rx_fifo_clear, error_check;
  logic [1:0]    rx_trigger;
  logic [7:0]    rsr_data;
  logic          frame_error, parity_error, sample_edge, rbr_read, lsr_read;
  logic [7:0]    rbr_data;
  logic          data_ready, lsr_frame_error, lsr_parity_error, overrun_error;
  logic          rx_fifo_error, trigger_reached, rx_timeout;
  logic [LW-1:0] rx_level;

  always #5 pclk = ~pclk;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TICKS)) dut (
    .pclk(pclk), .preset(preset), .utrrst(utrrst), .fifoen(fifoen),
    .rx_fifo_clear(rx_fifo_clear), .rx_trigger(rx_trigger), .error_check(error_check),
    .rsr_data(rsr_data), .frame_error(frame_error), .parity_error(parity_error),
    .sample_edge(sample_edge), .rbr_read(rbr_read), .lsr_read(lsr_read),
    .rbr_data(rbr_data), .data_ready(data_ready), .lsr_frame_error(lsr_frame_error),
    .lsr_parity_error(lsr_parity_error), .overrun_error(overrun_error),
    .rx_fifo_error(rx_fifo_error), .rx_level(rx_level),
    .trigger_reached(trigger_reached), .rx_timeout(rx_timeout)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] mq[$];     // model buffer contents, head first
  logic [9:0] exp_q[$];  // expected popped entries
  logic       fifo_m, ovr_m, tmo_m;
  int         cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the next expected entry.
  always @(negedge pclk) begin
    if (!preset && rbr_read && data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got %0h expected no pop", {lsr_frame_error, lsr_parity_error, rbr_data});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("pop_data", {lsr_frame_error, lsr_parity_error, rbr_data}, e);
      end
    end
  end

  // One clock of stimulus, called at posedge+1; updates the model and checks state after the edge.
  task automatic cyc(input logic ps, input logic [7:0] d, input logic [1:0] err, input logic pp,
                     input logic lr, input logic cl, input logic ur, input logic se);
    int cap, tl;
    logic flush, popok, set_ovr, act, pre_empty, ferr, trig;
    logic [9:0] ent;
    error_check = ps; rsr_data = d; frame_error = err[1]; parity_error = err[0];
    rbr_read = pp; lsr_read = lr; rx_fifo_clear = cl; utrrst = ur; sample_edge = se;
    ent       = {err, d};
    cap       = fifo_m ? DEPTH : 1;
    flush     = cl || ur || (fifoen != fifo_m);
    popok     = pp && (mq.size() > 0) && !flush;
    pre_empty = (mq.size() == 0);
    set_ovr   = 1'b0;
    act       = flush || popok;
    if (popok) exp_q.push_back(mq[0]);
    if (flush) begin
      mq.delete();
    end else begin
      if (popok) void'(mq.pop_front());
      if (ps) begin
        if (mq.size() < cap) begin
          mq.push_back(ent);
          act = 1'b1;
        end else begin
          set_ovr = 1'b1;
          if (!fifo_m) begin
            mq[0] = ent;
            act   = 1'b1;
          end
        end
      end
    end
    if (set_ovr) ovr_m = 1'b1;
    else if (ur || lr) ovr_m = 1'b0;
    if (act || pre_empty) begin
      cnt_m = 0;
      tmo_m = 1'b0;
    end else if (se && fifo_m && cnt_m < TICKS) begin
      cnt_m++;
      if (cnt_m == TICKS) tmo_m = 1'b1;
    end
    fifo_m = fifoen;

    @(posedge pclk); #1;
    ferr = 1'b0;
    foreach (mq[k]) if (mq[k][9:8] != 2'b00) ferr = 1'b1;
    case (rx_trigger)
      2'b00:   tl = 1;
      2'b01:   tl = 4;
      2'b10:   tl = 8;
      default: tl = 14;
    endcase
    trig = fifo_m ? (mq.size() >= tl) : (mq.size() > 0);
    chk("rx_level", rx_level, mq.size());
    chk("data_ready", data_ready, mq.size() > 0);
    chk("head", {lsr_frame_error, lsr_parity_error, rbr_data}, (mq.size() > 0) ? mq[0] : 10'h000);
    chk("overrun", overrun_error, ovr_m);
    chk("fifo_error", rx_fifo_error, ferr);
    chk("trigger", trigger_reached, trig);
`ifdef UART_RX_TIMEOUT_EN
    chk("timeout", rx_timeout, tmo_m);
`else
    chk("timeout", rx_timeout, 1'b0);
`endif
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] err);
    cyc(1'b1, d, err, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic pop();
    cyc(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle();
    cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int r;
    logic cl, ur, ps, pp;
    preset = 1'b1; utrrst = 1'b0; fifoen = 1'b1; rx_fifo_clear = 1'b0; rx_trigger = 2'b00;
    error_check = 1'b0; rsr_data = 8'h00; frame_error = 1'b0; parity_error = 1'b0;
    sample_edge = 1'b0; rbr_read = 1'b0; lsr_read = 1'b0;
    fifo_m = 1'b0; ovr_m = 1'b0; tmo_m = 1'b0; cnt_m = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_level", rx_level, 0);
    chk("reset_outputs", {rbr_data, data_ready, lsr_frame_error, lsr_parity_error, overrun_error,
                          rx_fifo_error, trigger_reached, rx_timeout}, 0);
    preset = 1'b0;
    idle(); idle();

    // basic ordering
    push(8'h41, 2'b00); push(8'h42, 2'b00); push(8'h43, 2'b00);
    chk("t1_level", rx_level, 3);
    chk("t1_head", rbr_data, 8'h41);
    pop(); pop(); pop();
    chk("t1_empty_ready", data_ready, 1'b0);
    chk("t1_empty_data", rbr_data, 8'h00);

    // overrun on full FIFO
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 2'b00);
    push(8'hAA, 2'b00);
    chk("t2_overrun", overrun_error, 1'b1);
    chk("t2_level", rx_level, DEPTH);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    chk("t2_last", rbr_data, 8'h1F);
    pop();
    cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_lsr_clear", overrun_error, 1'b0);

    // simultaneous push and pop, full then empty
    for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i), 2'b00);
    cyc(1'b1, 8'h77, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_full_level", rx_level, DEPTH);
    chk("t3_full_ovr", overrun_error, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop();
    cyc(1'b1, 8'h99, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_empty_level", rx_level, 1);
    pop();

    // error tracking
    push(8'h55, 2'b01); push(8'h66, 2'b00);
    chk("t4_fifo_err", rx_fifo_error, 1'b1);
    chk("t4_parity", lsr_parity_error, 1'b1);
    pop();
    chk("t4_parity_after", lsr_parity_error, 1'b0);
    chk("t4_fifo_err_after", rx_fifo_error, 1'b0);
    pop();

    // trigger level and mode-change flush
    rx_trigger = 2'b01;
    push(8'h01, 2'b00); push(8'h02, 2'b00); push(8'h03, 2'b00);
    chk("t5_trig3", trigger_reached, 1'b0);
    push(8'h04, 2'b00);
    chk("t5_trig4", trigger_reached, 1'b1);
    fifoen = 1'b0;
    idle();
    chk("t5_flush", rx_level, 0);

    // holding-register overwrite
    push(8'h12, 2'b00); push(8'h34, 2'b10);
    chk("t6_overrun", overrun_error, 1'b1);
    chk("t6_data", rbr_data, 8'h34);
    chk("t6_level", rx_level, 1);
    cyc(1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    fifoen = 1'b1;
    idle();

`ifdef UART_RX_TIMEOUT_EN
    push(8'h5A, 2'b00);
    for (int i = 0; i < TICKS - 1; i++) cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t7_before", rx_timeout, 1'b0);
    cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t7_timeout", rx_timeout, 1'b1);
    pop();
    chk("t7_cleared", rx_timeout, 1'b0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) fifoen = ~fifoen;
      if (r % 7 == 0) rx_trigger = 2'($urandom_range(0, 3));
      cl = ($urandom_range(0, 49) == 0);
      ur = ($urandom_range(0, 99) == 0);
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      if (cl || ur || r < 2) pp = 1'b0;
      cyc(ps, 8'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
          pp, ($urandom_range(0, 9) == 0), cl, ur, 1'($urandom_range(0, 1)));
    end

    idle(); idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer stage directly downstream of the UART receiver.
- Captures each completed character (rsr_data plus frame/parity status) on the receiver's error_check strobe.
- Buffers characters in a DEPTH-entry FIFO, or in a single holding register when FIFOs are disabled.
- Presents head-of-queue data and line-status flags to the APB register block, which pops on RBR reads.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4.
TIMEOUT_TICKS, 640, sample_edge pulses with no FIFO activity before rx_timeout asserts (only used with UART_RX_TIMEOUT_EN).

Ports:
pclk  input  1  APB/system clock.
preset  input  1  asynchronous active-high reset.
utrrst  input  1  synchronous receiver soft reset; flushes buffer and clears all flags.
fifoen  input  1  1 = FIFO mode (DEPTH entries), 0 = single holding register.
rx_fifo_clear  input  1  one-cycle synchronous flush request from FCR write.
rx_trigger  input  2  trigger level select: 00 = 1, 01 = 4, 10 = 8, 11 = 14 entries.
error_check  input  1  one-cycle push strobe from receiver at end of frame.
rsr_data  input  8  received character.
frame_error  input  1  frame error for the character being pushed.
parity_error  input  1  parity error for the character being pushed.
sample_edge  input  1  receiver sampling tick (timeout timebase).
rbr_read  input  1  one-cycle pop strobe (APB read of RBR).
lsr_read  input  1  one-cycle strobe (APB read of LSR); clears overrun.
rbr_data  output  8  head-entry data.
data_ready  output  1  buffer non-empty.
lsr_frame_error  output  1  head entry frame error.
lsr_parity_error  output  1  head entry parity error.
overrun_error  output  1  sticky overrun flag.
rx_fifo_error  output  1  at least one stored entry carries an error.
rx_level  output  $clog2(DEPTH)+1  current occupancy.
trigger_reached  output  1  rx_level >= selected trigger level (FIFO mode only; otherwise equals data_ready).
rx_timeout  output  1  character timeout indication.

Behaviour:
- Reset (preset high, asynchronous):
  - Pointers, level, error count and timeout counter = 0.
  - All outputs 0, including rbr_data = 8'h00.
- Storage:
  - Each entry is 10 bits: {frame_error, parity_error, rsr_data}.
  - Storage RAM needs no reset; head outputs read 0 whenever empty.
- Push: on error_check = 1.
  - Write occurs at the pclk edge; rx_level, data_ready and head outputs update in the next cycle (1-cycle latency).
- Pop: on rbr_read = 1 with rx_level > 0.
  - Head advances at the pclk edge.
  - rbr_read while empty has no effect on pointers or flags.
- Head outputs (rbr_data, lsr_frame_error, lsr_parity_error):
  - Driven from the read-pointer entry with no extra register stage.
  - Valid whenever data_ready = 1; 0 when empty.
- Full FIFO push (no pop that cycle): incoming character is discarded, FIFO contents are unchanged, overrun_error is set.
- Simultaneous push and pop:
  - When full: both occur, rx_level is unchanged, no overrun.
  - When empty: push occurs and the pop is ignored; rx_level becomes 1.
- Non-FIFO mode:
  - Depth is 1.
  - A push while data_ready = 1 overwrites the holding register and sets overrun_error.
- overrun_error:
  - Sticky; cleared on lsr_read.
  - If set and clear conditions occur in the same cycle, set wins.
- rx_fifo_error:
  - Driven by a counter of stored entries with frame or parity error; increments on push of an errored entry, decrements on pop of an errored entry.
  - Output = (count != 0).
- Flush: rx_fifo_clear = 1, utrrst = 1, or any change of fifoen (fifoen registered, compared each cycle).
  - Empties the buffer and zeroes the error count and timeout counter.
  - utrrst also clears overrun_error; rx_fifo_clear does not.
  - A push coinciding with a flush is dropped.
- rx_level arithmetic: width $clog2(DEPTH)+1; never exceeds DEPTH and never wraps below 0.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- trigger_reached: combinational compare of rx_level against the decoded trigger level; held 0 in non-FIFO mode except as data_ready.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - Timeout counter increments on each sample_edge while fifoen = 1 and rx_level > 0.
  - Counter resets to 0 on push, pop, flush, or when empty.
  - When the counter reaches TIMEOUT_TICKS, rx_timeout sets and holds (counter saturates) until the next push, pop or flush.
- Undefined: no counter logic is built; rx_timeout is tied to 0.

Test Plan:
- Reset, then 3 pushes 8'h41, 8'h42, 8'h43 in FIFO mode → rx_level = 3, rbr_data = 8'h41. Three rbr_read pops return 41, 42, 43, after which data_ready = 0 and rbr_data = 0.
- Fill 16 entries, push 8'hAA → overrun_error = 1, rx_level = 16, 16th pop returns the original 16th byte (not AA). lsr_read → overrun_error = 0.
- Full FIFO, push and pop in the same cycle → rx_level stays 16, no overrun. Empty FIFO, push and pop in the same cycle → rx_level = 1.
- Push 8'h55 with parity_error = 1 then 8'h66 clean → rx_fifo_error = 1, lsr_parity_error = 1. After one pop: lsr_parity_error = 0 and rx_fifo_error = 0.
- rx_trigger = 2'b01, push 3 then 4 entries → trigger_reached = 0 at level 3, 1 at level 4. Toggle fifoen → buffer flushed, rx_level = 0.
- UART_RX_TIMEOUT_EN, TIMEOUT_TICKS = 640, 1 entry stored, 640 sample_edge pulses with no activity → rx_timeout = 1. Pop → rx_timeout = 0.
